uart_frame_assembler: RTL and testbench

Downstream consumer of the serial nibble receiver. Collects three consecutive received nibbles into one command frame: operand A, then operand B, then opcode. Presents the frame to the ALU/control stage with a valid/ready handshake. An inter-nibble timeout drops partial frames, so a lost nibble never misaligns later frames.

---
 rtl/uart_frame_assembler.sv | 133 +++++++++++++
 tb/tb_uart_frame_assembler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_assembler.sv
// Collects operand A, operand B and opcode nibbles into one frame with valid/ready handoff.
// Optional OPCODE_CHECK_EN rejects opcodes >= NUM_OPS.
module uart_frame_assembler #(
   parameter int TIMEOUT_CLKS = 5000000,
   parameter int TO_W         = 23,
   parameter int NUM_OPS      = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] nib_in,
   input  logic       nib_valid,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic [3:0] opcode,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       err_opcode
);

   typedef enum logic [1:0] {
      WAIT_A  = 2'd0,
      WAIT_B  = 2'd1,
      WAIT_OP = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] CNT_LAST  = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [4:0]      NUM_OPS_L = 5'(NUM_OPS);
`ifdef OPCODE_CHECK_EN
   localparam logic OPCHK = 1'b1;
`else
   localparam logic OPCHK = 1'b0;
`endif

   state_t          state_r;
   logic [3:0]      stage_a_r;
   logic [3:0]      stage_b_r;
   logic [TO_W-1:0] cnt_r;
   logic            bad_op_s;

   // Opcode legality; constant false when the check is not built in.
   assign bad_op_s = OPCHK & ({1'b0, nib_in} >= NUM_OPS_L);

   // Frame assembly FSM with registered outputs and error pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= WAIT_A;
         stage_a_r   <= 4'd0;
         stage_b_r   <= 4'd0;
         cnt_r       <= {TO_W{1'b0}};
         op_a        <= 4'd0;
         op_b        <= 4'd0;
         opcode      <= 4'd0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         err_opcode  <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
         err_opcode  <= 1'b0;
         case (state_r)
            WAIT_A: begin
               if (nib_valid) begin
                  stage_a_r <= nib_in;
                  cnt_r     <= {TO_W{1'b0}};
                  busy      <= 1'b1;
                  state_r   <= WAIT_B;
               end else begin
                  state_r <= WAIT_A;
               end
            end
            WAIT_B, WAIT_OP: begin
               if (nib_valid) begin
                  cnt_r <= {TO_W{1'b0}};
                  if (state_r == WAIT_B) begin
                     stage_b_r <= nib_in;
                     state_r   <= WAIT_OP;
                  end else if (bad_op_s) begin
                     err_opcode <= 1'b1;
                     busy       <= 1'b0;
                     state_r    <= WAIT_A;
                  end else begin
                     op_a        <= stage_a_r;
                     op_b        <= stage_b_r;
                     opcode      <= nib_in;
                     frame_valid <= 1'b1;
                     busy        <= 1'b0;
                     state_r     <= HOLD;
                  end
               end else if (cnt_r == CNT_LAST) begin
                  // Inter-nibble gap too long: drop the partial frame to stay aligned.
                  stage_a_r   <= 4'd0;
                  stage_b_r   <= 4'd0;
                  cnt_r       <= {TO_W{1'b0}};
                  err_timeout <= 1'b1;
                  busy        <= 1'b0;
                  state_r     <= WAIT_A;
               end else begin
                  cnt_r <= cnt_r + TO_W'(1);
               end
            end
            HOLD: begin
               if (frame_ready) begin
                  frame_valid <= 1'b0;
                  if (nib_valid) begin
                     stage_a_r <= nib_in;
                     cnt_r     <= {TO_W{1'b0}};
                     busy      <= 1'b1;
                     state_r   <= WAIT_B;
                  end else begin
                     state_r <= WAIT_A;
                  end
               end else if (nib_valid) begin
                  err_overrun <= 1'b1;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               frame_valid <= 1'b0;
               busy        <= 1'b0;
               state_r     <= WAIT_A;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: directed scenarios then randomized traffic
// checked against a queue-based reference model.
module tb_uart_frame_assembler;

   localparam int TO      = 100;
   localparam int NUM_OPS = 10;
`ifdef OPCODE_CHECK_EN
   localparam bit OPCHK = 1'b1;
`else
   localparam bit OPCHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] nib_in = 4'd0;
   logic       nib_valid = 1'b0;
   logic       frame_ready = 1'b0;
   logic [3:0] op_a, op_b, opcode;
   logic       frame_valid, busy, err_timeout, err_overrun, err_opcode;

   uart_frame_assembler #(.TIMEOUT_CLKS(TO), .TO_W(7), .NUM_OPS(NUM_OPS)) dut (
      .clk(clk), .reset(reset), .nib_in(nib_in), .nib_valid(nib_valid),
      .op_a(op_a), .op_b(op_b), .opcode(opcode), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .busy(busy), .err_timeout(err_timeout),
      .err_overrun(err_overrun), .err_opcode(err_opcode)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // Reference model: collected nibbles, idle count, held frame, last-step errors.
   logic [3:0]  m_part[$];
   int          m_idle;
   bit          m_held;
   logic [11:0] m_last;
   bit          m_to, m_ov, m_op;
   logic [11:0] sb[$];

   // Expected values visible on the DUT outputs during the current cycle.
   bit          ev_busy, ev_valid, ev_to, ev_ov, ev_op;
   logic [11:0] ev_frame;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic publish();
      ev_busy  = (m_part.size() != 0);
      ev_valid = m_held;
      ev_to    = m_to;
      ev_ov    = m_ov;
      ev_op    = m_op;
      ev_frame = m_last;
   endtask

   task automatic model_clear();
      m_part.delete();
      sb.delete();
      m_idle = 0;
      m_held = 1'b0;
      m_last = 12'd0;
      m_to = 1'b0; m_ov = 1'b0; m_op = 1'b0;
   endtask

   task automatic model_update(input bit nv, input logic [3:0] nib, input bit rdy);
      m_to = 1'b0; m_ov = 1'b0; m_op = 1'b0;
      if (m_held) begin
         if (rdy) begin
            m_held = 1'b0;
            if (nv) begin
               m_part.push_back(nib);
               m_idle = 0;
            end
         end else if (nv) begin
            m_ov = 1'b1;
         end
      end else if (m_part.size() == 0) begin
         if (nv) begin
            m_part.push_back(nib);
            m_idle = 0;
         end
      end else if (nv) begin
         m_idle = 0;
         if (m_part.size() == 1) begin
            m_part.push_back(nib);
         end else if (OPCHK && (int'(nib) >= NUM_OPS)) begin
            m_op = 1'b1;
            m_part.delete();
         end else begin
            m_last = {m_part[0], m_part[1], nib};
            sb.push_back(m_last);
            m_held = 1'b1;
            m_part.delete();
         end
      end else if (m_idle == TO - 1) begin
         m_to = 1'b1;
         m_idle = 0;
         m_part.delete();
      end else begin
         m_idle++;
      end
   endtask

   task automatic step(input bit nv, input logic [3:0] nib, input bit rdy);
      publish();
      nib_valid   = nv;
      nib_in      = nib;
      frame_ready = rdy;
      model_update(nv, nib, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      nib_valid = 1'b0;
      frame_ready = 1'b0;
      model_clear();
      publish();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic send3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      step(1'b1, a, 1'b0);
      step(1'b1, b, 1'b0);
      step(1'b1, c, 1'b0);
   endtask

   // Monitor: per-cycle status checks and scoreboard pop on each frame handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", 32'(busy), 32'(ev_busy));
         chk("frame_valid", 32'(frame_valid), 32'(ev_valid));
         chk("err_timeout", 32'(err_timeout), 32'(ev_to));
         chk("err_overrun", 32'(err_overrun), 32'(ev_ov));
         chk("err_opcode", 32'(err_opcode), 32'(ev_op));
         chk("frame_regs", 32'({op_a, op_b, opcode}), 32'(ev_frame));
         if (frame_valid && frame_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_frame", 32'({op_a, op_b, opcode}), 32'hFFFF_FFFF);
            end else begin
               chk("sb_frame", 32'({op_a, op_b, opcode}), 32'(sb.pop_front()));
            end
         end
      end
   end

   initial begin
      model_clear();
      publish();
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      do_reset();

      // Basic frame, held until ready.
      send3(4'd3, 4'd5, 4'd2);
      step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b0);

      // Timeout drops the lone 7, then a clean frame.
      step(1'b1, 4'd7, 1'b0);
      repeat (TO) step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      send3(4'd1, 4'd2, 4'd4);
      step(1'b0, 4'd0, 1'b1);

      // Nibble arrives exactly at counter expiry: accepted, no error.
      step(1'b1, 4'd7, 1'b0);
      repeat (TO - 1) step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd6, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b0, 4'd0, 1'b1);

      // Overrun while held, then ready coincident with the next nibble.
      send3(4'd1, 4'd2, 4'd3);
      step(1'b1, 4'd9, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd4, 1'b1);
      step(1'b1, 4'd5, 1'b0);
      step(1'b1, 4'd6, 1'b0);
      step(1'b0, 4'd0, 1'b1);

      // Reset mid-frame.
      step(1'b1, 4'd8, 1'b0);
      step(1'b1, 4'd8, 1'b0);
      do_reset();
      send3(4'd1, 4'd1, 4'd1);
      step(1'b0, 4'd0, 1'b1);

      // Out-of-range opcode (rejected only when the check is built in).
      send3(4'd2, 4'd3, 4'd12);
      step(1'b0, 4'd0, 1'b0);
      step(1'b0, 4'd0, 1'b1);
      step(1'b0, 4'd0, 1'b0);

      // Randomized traffic with occasional long gaps and resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            repeat ($urandom_range(TO - 5, TO + 5))
               step(1'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
         end else if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 30));
         end
      end

      // Drain any held frame.
      repeat (4) step(1'b0, 4'd0, 1'b1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
